// File: rtl/misr_response_compactor.sv
`default_nettype none
// ============================================================================
// misr_response_compactor -- folds per-pattern response vectors into a MISR
// and compares the final signature against a golden value.
// Revision: 1.0
// ============================================================================
module misr_response_compactor #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = 16'h1021,
   parameter logic [WIDTH-1:0] SEED  = 16'h0000,
   parameter int               CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [CNT_W-1:0] NUM_PAT,
   input  logic [WIDTH-1:0] GOLDEN,
   input  logic             RESP_VALID,
   input  logic [WIDTH-1:0] RESP,
   output logic             RESP_READY,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [WIDTH-1:0] SIGNATURE,
   output logic [CNT_W-1:0] PAT_COUNT
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sig_q, sig_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [WIDTH-1:0] gold_q, gold_d;
   logic             pass_q, pass_d;
   logic [WIDTH-1:0] misr_next;
   logic [CNT_W-1:0] cnt_inc;

   assign misr_next = {sig_q[WIDTH-2:0], 1'b0}
                    ^ (sig_q[WIDTH-1] ? POLY : {WIDTH{1'b0}})
                    ^ RESP;
   assign cnt_inc   = cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      gold_d  = gold_q;
      pass_d  = pass_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               sig_d   = SEED;
               cnt_d   = '0;
               num_d   = NUM_PAT;
               gold_d  = GOLDEN;
               pass_d  = 1'b0;
               state_d = (NUM_PAT == '0) ? ST_CHECK : ST_RUN;
            end
         end
         ST_RUN: begin
            if (RESP_VALID) begin
               sig_d = misr_next;
               cnt_d = cnt_inc;
               // Compare the incremented count so the run ends on the final beat
               if (cnt_inc == num_q) begin
                  state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            pass_d  = (sig_q == gold_q);
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         num_q   <= '0;
         gold_q  <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         gold_q  <= gold_d;
         pass_q  <= pass_d;
      end
   end

   assign RESP_READY = (state_q == ST_RUN);
   assign BUSY       = (state_q == ST_RUN) || (state_q == ST_CHECK);
   assign DONE       = (state_q == ST_DONE);
   assign PASS       = pass_q;
   assign SIGNATURE  = sig_q;
   assign PAT_COUNT  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_misr_response_compactor.sv
`default_nettype none
// Bench for misr_response_compactor: directed scenarios plus randomized runs
// checked against a GF(2) polynomial-remainder model of the signature.
module tb_misr_response_compactor;

   localparam int          WIDTH = 16;
   localparam int          CNT_W = 16;
   localparam logic [16:0] FULL_POLY = 17'h11021;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             START = 1'b0;
   logic [CNT_W-1:0] NUM_PAT = '0;
   logic [WIDTH-1:0] GOLDEN = '0;
   logic             RESP_VALID = 1'b0;
   logic [WIDTH-1:0] RESP = '0;
   logic             RESP_READY, BUSY, DONE, PASS;
   logic [WIDTH-1:0] SIGNATURE;
   logic [CNT_W-1:0] PAT_COUNT;

   int total = 0;
   int bad   = 0;
   logic [15:0] resp_q[$];

   misr_response_compactor dut (
      .CLK(CLK), .RST(RST), .START(START), .NUM_PAT(NUM_PAT), .GOLDEN(GOLDEN),
      .RESP_VALID(RESP_VALID), .RESP(RESP), .RESP_READY(RESP_READY),
      .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .SIGNATURE(SIGNATURE),
      .PAT_COUNT(PAT_COUNT)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Signature as polynomial remainder: (seed*x^n + sum r_i*x^(n-1-i)) mod P
   function automatic logic [15:0] model_sig(input logic [15:0] seed, input int n);
      logic [31:0] acc;
      acc = {16'h0, seed};
      for (int i = 0; i < n; i++) begin
         acc = (acc << 1) ^ {16'h0, resp_q[i]};
         for (int b = 31; b >= 16; b--)
            if (acc[b]) acc = acc ^ ({15'h0, FULL_POLY} << (b - 16));
      end
      return acc[15:0];
   endfunction

   // Starts a run and feeds resp_q until DONE, with randomized valid gaps.
   task automatic do_run(input logic [15:0] n, input logic [15:0] golden, input int valid_pct);
      int idx, cyc;
      START = 1'b1; NUM_PAT = n; GOLDEN = golden;
      tick();
      START = 1'b0;
      idx = 0; cyc = 0;
      while (!DONE && cyc < 400) begin
         RESP_VALID = ($urandom_range(99) < valid_pct);
         RESP       = (idx < resp_q.size()) ? resp_q[idx] : 16'($urandom);
         if (RESP_VALID && RESP_READY) idx++;
         tick();
         cyc++;
      end
      RESP_VALID = 1'b0;
      total++;
      if (!DONE || idx != int'(n)) begin
         bad++;
         $display("FAIL run_complete: done=%0b beats=%0d required done=1 beats=%0d", DONE, idx, n);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; START = 1'b1;
      tick();
      RST = 1'b0; START = 1'b0;
      total++;
      if ({RESP_READY, BUSY, DONE, PASS} !== 4'b0000 || SIGNATURE !== 16'h0000 || PAT_COUNT !== 16'h0) begin
         bad++;
         $display("FAIL reset_state: flags=%b sig=%h cnt=%0d required flags=0000 sig=0000 cnt=0",
                  {RESP_READY, BUSY, DONE, PASS}, SIGNATURE, PAT_COUNT);
      end
   endtask

   task automatic test_single_beat();
      START = 1'b1; NUM_PAT = 16'd1; GOLDEN = 16'h0001;
      tick();
      START = 1'b0; RESP_VALID = 1'b1; RESP = 16'h0001;
      total++;
      if (RESP_READY !== 1'b1 || BUSY !== 1'b1) begin
         bad++; $display("FAIL single_ready: ready=%b busy=%b required 1 1", RESP_READY, BUSY);
      end
      tick();
      RESP_VALID = 1'b0;
      total++;
      if (DONE !== 1'b0 || RESP_READY !== 1'b0 || SIGNATURE !== 16'h0001 || PASS !== 1'b0) begin
         bad++;
         $display("FAIL single_check_cycle: done=%b ready=%b pass=%b sig=%h required 0 0 0 0001",
                  DONE, RESP_READY, PASS, SIGNATURE);
      end
      tick();
      total++;
      if (DONE !== 1'b1 || PASS !== 1'b1 || PAT_COUNT !== 16'd1) begin
         bad++; $display("FAIL single_done: done=%b pass=%b cnt=%0d required 1 1 1", DONE, PASS, PAT_COUNT);
      end
   endtask

   task automatic test_feedback();
      for (int k = 0; k < 2; k++) begin
         logic [15:0] g;
         g = (k == 0) ? 16'h1021 : 16'h1020;
         resp_q = '{16'h8000, 16'h0000};
         START = 1'b1; NUM_PAT = 16'd2; GOLDEN = g;
         tick();
         START = 1'b0; RESP_VALID = 1'b1; RESP = 16'h8000;
         tick();
         total++;
         if (SIGNATURE !== 16'h8000) begin
            bad++; $display("FAIL feedback_first: sig=%h required 8000", SIGNATURE);
         end
         RESP = 16'h0000;
         tick();
         RESP_VALID = 1'b0;
         tick();
         total++;
         if (DONE !== 1'b1 || SIGNATURE !== 16'h1021 || PAT_COUNT !== 16'd2 || PASS !== (k == 0)) begin
            bad++;
            $display("FAIL feedback_golden_%0d: done=%b sig=%h cnt=%0d pass=%b required 1 1021 2 %b",
                     k, DONE, SIGNATURE, PAT_COUNT, PASS, (k == 0));
         end
      end
   endtask

   task automatic test_gaps();
      logic [15:0] exp_sig;
      resp_q = '{16'($urandom), 16'($urandom), 16'($urandom)};
      exp_sig = model_sig(16'h0000, 3);
      START = 1'b1; NUM_PAT = 16'd3; GOLDEN = exp_sig;
      tick();
      START = 1'b0;
      RESP_VALID = 1'b1; RESP = resp_q[0]; tick();
      RESP_VALID = 1'b0; tick(); tick();
      RESP_VALID = 1'b1; RESP = resp_q[1]; tick();
      RESP = resp_q[2]; tick();
      RESP = 16'hDEAD;
      total++;
      if (RESP_READY !== 1'b0 || BUSY !== 1'b1 || PAT_COUNT !== 16'd3) begin
         bad++; $display("FAIL gaps_check_state: ready=%b busy=%b cnt=%0d required 0 1 3", RESP_READY, BUSY, PAT_COUNT);
      end
      tick(); tick();
      total++;
      if (RESP_READY !== 1'b0 || DONE !== 1'b1 || PAT_COUNT !== 16'd3 || SIGNATURE !== exp_sig || PASS !== 1'b1) begin
         bad++;
         $display("FAIL gaps_done: ready=%b done=%b cnt=%0d sig=%h pass=%b required 0 1 3 %h 1",
                  RESP_READY, DONE, PAT_COUNT, SIGNATURE, PASS, exp_sig);
      end
      RESP_VALID = 1'b0;
   endtask

   task automatic test_zero_patterns();
      for (int k = 0; k < 2; k++) begin
         logic saw_ready;
         logic [15:0] g;
         g = (k == 0) ? 16'h0000 : 16'h0005;
         saw_ready = 1'b0;
         START = 1'b1; NUM_PAT = 16'd0; GOLDEN = g; RESP_VALID = 1'b1; RESP = 16'h1234;
         tick();
         START = 1'b0;
         saw_ready = saw_ready | RESP_READY;
         total++;
         if (BUSY !== 1'b1 || DONE !== 1'b0 || PASS !== 1'b0) begin
            bad++; $display("FAIL zero_check: busy=%b done=%b pass=%b required 1 0 0", BUSY, DONE, PASS);
         end
         tick();
         saw_ready = saw_ready | RESP_READY;
         total++;
         if (DONE !== 1'b1 || SIGNATURE !== 16'h0000 || PASS !== (k == 0) || saw_ready !== 1'b0) begin
            bad++;
            $display("FAIL zero_done_%0d: done=%b sig=%h pass=%b ready_seen=%b required 1 0000 %b 0",
                     k, DONE, SIGNATURE, PASS, saw_ready, (k == 0));
         end
         RESP_VALID = 1'b0;
      end
      // Restart from DONE: DONE and PASS must drop the next cycle
      START = 1'b1; NUM_PAT = 16'd0; GOLDEN = 16'h0000;
      tick();
      START = 1'b0;
      total++;
      if (DONE !== 1'b0 || PASS !== 1'b0 || BUSY !== 1'b1) begin
         bad++; $display("FAIL restart_from_done: done=%b pass=%b busy=%b required 0 0 1", DONE, PASS, BUSY);
      end
      tick();
   endtask

   task automatic test_reset_midrun();
      START = 1'b1; NUM_PAT = 16'd4; GOLDEN = 16'h0000;
      tick();
      START = 1'b0; RESP_VALID = 1'b1; RESP = 16'hA5A5;
      tick();
      RESP_VALID = 1'b1; RST = 1'b1; START = 1'b1;
      tick();
      RST = 1'b0; START = 1'b0; RESP_VALID = 1'b0;
      total++;
      if ({RESP_READY, BUSY, DONE, PASS} !== 4'b0000 || SIGNATURE !== 16'h0000 || PAT_COUNT !== 16'h0) begin
         bad++;
         $display("FAIL reset_midrun: flags=%b sig=%h cnt=%0d required 0000 0000 0",
                  {RESP_READY, BUSY, DONE, PASS}, SIGNATURE, PAT_COUNT);
      end
      tick();
      total++;
      if (BUSY !== 1'b0) begin
         bad++; $display("FAIL reset_stays_idle: busy=%b required 0", BUSY);
      end
      // START during RUN must not restart or alter the count
      START = 1'b1; NUM_PAT = 16'd2; GOLDEN = 16'h0000;
      tick();
      START = 1'b0; RESP_VALID = 1'b1; RESP = 16'h0F0F;
      tick();
      RESP_VALID = 1'b0; START = 1'b1; NUM_PAT = 16'd9;
      tick(); tick();
      START = 1'b0;
      total++;
      if (PAT_COUNT !== 16'd1 || BUSY !== 1'b1 || SIGNATURE !== 16'h0F0F) begin
         bad++; $display("FAIL start_in_run: cnt=%0d busy=%b sig=%h required 1 1 0f0f", PAT_COUNT, BUSY, SIGNATURE);
      end
      RESP_VALID = 1'b1; RESP = 16'h0000;
      tick();
      RESP_VALID = 1'b0;
      tick();
      total++;
      if (DONE !== 1'b1 || PAT_COUNT !== 16'd2) begin
         bad++; $display("FAIL start_in_run_end: done=%b cnt=%0d required 1 2", DONE, PAT_COUNT);
      end
   endtask

   task automatic test_max_count_start();
      START = 1'b1; NUM_PAT = 16'hFFFF; GOLDEN = 16'h0000;
      tick();
      START = 1'b0; RESP_VALID = 1'b1; RESP = 16'h0001;
      repeat (20) tick();
      RESP_VALID = 1'b0;
      total++;
      if (PAT_COUNT !== 16'd20 || BUSY !== 1'b1 || DONE !== 1'b0) begin
         bad++; $display("FAIL max_numpat_running: cnt=%0d busy=%b done=%b required 20 1 0", PAT_COUNT, BUSY, DONE);
      end
      RST = 1'b1; tick(); RST = 1'b0;
   endtask

   task automatic test_random_runs();
      for (int r = 0; r < 8; r++) begin
         int n;
         logic [15:0] exp_sig, g;
         logic exp_pass;
         n = int'($urandom_range(1, 24));
         resp_q.delete();
         for (int i = 0; i < n; i++) resp_q.push_back(16'($urandom));
         exp_sig  = model_sig(16'h0000, n);
         exp_pass = $urandom_range(1);
         g = exp_pass ? exp_sig : exp_sig ^ (16'h1 << $urandom_range(15));
         do_run(16'(n), g, 60);
         total++;
         if (SIGNATURE !== exp_sig || PASS !== exp_pass || PAT_COUNT !== 16'(n)) begin
            bad++;
            $display("FAIL random_run_%0d: sig=%h pass=%b cnt=%0d required %h %b %0d",
                     r, SIGNATURE, PASS, PAT_COUNT, exp_sig, exp_pass, n);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_feedback();
      test_gaps();
      test_zero_patterns();
      test_reset_midrun();
      test_max_count_start();
      test_random_runs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
